// File: rtl/multicycle_instruction_decoder_pkg.sv
// picoMIPS decoder shared definitions: opcode encodings, flag bit indices and FSM state type.
package picomips_pkg;

    localparam logic [5:0] NOP  = 6'h00;
    localparam logic [5:0] ADD  = 6'h02;
    localparam logic [5:0] SUB  = 6'h03;
    localparam logic [5:0] MUL  = 6'h04;
    localparam logic [5:0] ADDI = 6'h0A;
    localparam logic [5:0] SUBI = 6'h0B;
    localparam logic [5:0] MULI = 6'h0C;
    localparam logic [5:0] BEQ  = 6'h18;
    localparam logic [5:0] BNE  = 6'h19;
    localparam logic [5:0] BGE  = 6'h1A;
    localparam logic [5:0] J    = 6'h20;
    localparam logic [5:0] IN   = 6'h30;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;

    typedef enum logic [1:0] {
        EXEC     = 2'd0,
        MUL_BUSY = 2'd1,
        IN_WAIT  = 2'd2
    } dec_state_t;

endpackage

// File: rtl/multicycle_instruction_decoder_branch_cond.sv
// Conditional-branch evaluation: decides whether BEQ/BNE/BGE is taken from the supplied flags.
module branch_cond
    import picomips_pkg::*;
#(
    parameter int OPCODE_WIDTH = 6,
    parameter int FLAG_WIDTH   = 3
) (
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [FLAG_WIDTH-1:0]   flags,
    output logic                    taken
);

    // Carry is not consulted by any branch in this ISA.
    logic flags_unused;
    assign flags_unused = flags[FLAG_C];

    always_comb begin
        taken = 1'b0;
        case (opcode)
            BEQ:     taken = flags[FLAG_Z];
            BNE:     taken = ~flags[FLAG_Z];
            BGE:     taken = ~flags[FLAG_N];
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_instruction_decoder.sv
// picoMIPS multi-cycle decoder: single-cycle ops decoded directly, MUL/MULI and IN sequenced by stalling the PC.
// Define DECODER_FLAG_LATCH_EN to make branches test flags captured at the last ALU write instead of live flags.
module multicycle_instruction_decoder
    import picomips_pkg::*;
#(
    parameter int OPCODE_WIDTH = 6,
    parameter int FUNC_WIDTH   = 3,
    parameter int FLAG_WIDTH   = 3,
    parameter int MUL_CYCLES   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [FLAG_WIDTH-1:0]   flags,
    input  logic                    in_valid,
    output logic                    PC_incr,
    output logic                    PC_abs_branch,
    output logic                    PC_rel_branch,
    output logic [FUNC_WIDTH-1:0]   ALU_func,
    output logic                    imm,
    output logic                    we,
    output logic                    in_sel,
    output logic                    in_ack,
    output logic                    mul_start,
    output logic                    stall
);

    localparam int CNT_W = $clog2(MUL_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (MUL_CYCLES > 1) ? CNT_W'(MUL_CYCLES - 2) : '0;

    dec_state_t             state, next_state;
    logic [CNT_W-1:0]       cnt, next_cnt;
    logic [FLAG_WIDTH-1:0]  flags_eff;
    logic                   taken;

`ifdef DECODER_FLAG_LATCH_EN
    logic [FLAG_WIDTH-1:0] flags_q;

    // Only ALU writes update the condition; IN writes go through in_sel and are excluded.
    always_ff @(posedge clk) begin
        if (reset)
            flags_q <= '0;
        else if (we && !in_sel)
            flags_q <= flags;
    end

    assign flags_eff = flags_q;
`else
    assign flags_eff = flags;
`endif

    branch_cond #(
        .OPCODE_WIDTH (OPCODE_WIDTH),
        .FLAG_WIDTH   (FLAG_WIDTH)
    ) u_branch_cond (
        .opcode (opcode),
        .flags  (flags_eff),
        .taken  (taken)
    );

    always_comb begin
        PC_incr       = 1'b0;
        PC_abs_branch = 1'b0;
        PC_rel_branch = 1'b0;
        ALU_func      = '0;
        imm           = 1'b0;
        we            = 1'b0;
        in_sel        = 1'b0;
        in_ack        = 1'b0;
        mul_start     = 1'b0;
        stall         = 1'b0;
        next_state    = state;
        next_cnt      = cnt;

        if (!reset) begin
            case (state)
                EXEC: begin
                    PC_incr = 1'b1;
                    case (opcode)
                        ADD, SUB: begin
                            we       = 1'b1;
                            ALU_func = opcode[FUNC_WIDTH-1:0];
                        end
                        ADDI, SUBI: begin
                            we       = 1'b1;
                            imm      = 1'b1;
                            ALU_func = opcode[FUNC_WIDTH-1:0];
                        end
                        BEQ, BNE, BGE: begin
                            if (taken) begin
                                PC_incr       = 1'b0;
                                PC_rel_branch = 1'b1;
                            end
                        end
                        J: begin
                            PC_incr       = 1'b0;
                            PC_abs_branch = 1'b1;
                        end
                        MUL, MULI: begin
                            mul_start = 1'b1;
                            imm       = (opcode == MULI);
                            ALU_func  = opcode[FUNC_WIDTH-1:0];
                            if (MUL_CYCLES == 1) begin
                                we = 1'b1;
                            end else begin
                                PC_incr    = 1'b0;
                                stall      = 1'b1;
                                next_cnt   = CNT_INIT;
                                next_state = MUL_BUSY;
                            end
                        end
                        IN: begin
                            if (in_valid) begin
                                we     = 1'b1;
                                in_sel = 1'b1;
                                in_ack = 1'b1;
                            end else begin
                                PC_incr    = 1'b0;
                                stall      = 1'b1;
                                next_state = IN_WAIT;
                            end
                        end
                        default: ;
                    endcase
                end
                MUL_BUSY: begin
                    // PC is frozen, so the opcode still names the MUL/MULI in flight.
                    ALU_func = opcode[FUNC_WIDTH-1:0];
                    imm      = (opcode == MULI);
                    if (cnt != '0) begin
                        stall    = 1'b1;
                        next_cnt = cnt - CNT_W'(1);
                    end else begin
                        we         = 1'b1;
                        PC_incr    = 1'b1;
                        next_state = EXEC;
                    end
                end
                IN_WAIT: begin
                    if (in_valid) begin
                        we         = 1'b1;
                        in_sel     = 1'b1;
                        in_ack     = 1'b1;
                        PC_incr    = 1'b1;
                        next_state = EXEC;
                    end else begin
                        stall = 1'b1;
                    end
                end
                default: next_state = EXEC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EXEC;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

endmodule
